// File: rtl/reg_writeback.sv
// reg_writeback: writeback stage with integrated register file.
// Selects the writeback result (with byte/half memory extraction and sign
// or zero extension), commits it to the register file and counts commits.
// Optional feature macro: REG_WRITEBACK_BYPASS_EN enables write-then-read
// bypass on both read ports. Default build (macro undefined) returns the
// stored value; new data becomes visible the cycle after commit.
module reg_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            RegWriteW,
    input  logic [1:0]            ResultSrcW,
    input  logic [ADDR_WIDTH-1:0] RdW,
    input  logic [DATA_WIDTH-1:0] ALUResultW,
    input  logic [DATA_WIDTH-1:0] ReadDataW,
    input  logic [DATA_WIDTH-1:0] PCPlus4W,
    input  logic [DATA_WIDTH-1:0] ImmExtW,
    input  logic [ADDR_WIDTH-1:0] RA1,
    input  logic [ADDR_WIDTH-1:0] RA2,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic [DATA_WIDTH-1:0] ResultW,
    output logic [DATA_WIDTH-1:0] a0,
    output logic [31:0]           WbCount
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] A0_IDX   = ADDR_WIDTH'(10);

    // Extracts the addressed byte/half lane of the aligned memory word and
    // extends it according to the write code; other codes pass the word.
    function automatic logic [DATA_WIDTH-1:0] extend_mem(
        input logic [2:0]            code,
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            offset
    );
        logic [7:0]            byte_v;
        logic [15:0]           half_v;
        logic [DATA_WIDTH-1:0] ext_v;
        case (offset)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = 8'h00;
        endcase
        // offset[0] is ignored for halfword lanes
        if (offset[1]) begin
            half_v = word[31:16];
        end else begin
            half_v = word[15:0];
        end
        case (code)
            3'b010:  ext_v = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            3'b011:  ext_v = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            3'b100:  ext_v = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            3'b101:  ext_v = {{(DATA_WIDTH-16){1'b0}}, half_v};
            default: ext_v = word;
        endcase
        return ext_v;
    endfunction

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [31:0]           wb_count_r;
    logic [DATA_WIDTH-1:0] result_s;
    logic                  code_valid_s;
    logic                  write_en_s;
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rd2_s;

    // Result source mux; the value is driven even when no write happens.
    always_comb begin
        result_s = {DATA_WIDTH{1'b0}};
        case (ResultSrcW)
            2'b00:   result_s = ALUResultW;
            2'b01:   result_s = extend_mem(RegWriteW, ReadDataW, ALUResultW[1:0]);
            2'b10:   result_s = PCPlus4W;
            2'b11:   result_s = ImmExtW;
            default: result_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // A write commits for codes 001..101 to any register other than x0.
    always_comb begin
        code_valid_s = 1'b0;
        case (RegWriteW)
            3'b001, 3'b010, 3'b011, 3'b100, 3'b101: code_valid_s = 1'b1;
            default:                                 code_valid_s = 1'b0;
        endcase
        if (RdW != ZERO_IDX) begin
            write_en_s = code_valid_s;
        end else begin
            write_en_s = 1'b0;
        end
    end

    // Register file storage; reset clears every entry immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (write_en_s) begin
            regs_r[RdW] <= result_s;
        end
    end

    // Commit counter; wraps silently at the top of its range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_count_r <= 32'h0000_0000;
        end else if (write_en_s) begin
            wb_count_r <= wb_count_r + 32'h0000_0001;
        end
    end

    // Read port 1: x0 is hardwired to zero.
    always_comb begin
        rd1_s = {DATA_WIDTH{1'b0}};
        if (RA1 == ZERO_IDX) begin
            rd1_s = {DATA_WIDTH{1'b0}};
        end
`ifdef REG_WRITEBACK_BYPASS_EN
        else if (write_en_s && (RA1 == RdW)) begin
            rd1_s = result_s;
        end
`endif
        else begin
            rd1_s = regs_r[RA1];
        end
    end

    // Read port 2: identical behaviour to port 1.
    always_comb begin
        rd2_s = {DATA_WIDTH{1'b0}};
        if (RA2 == ZERO_IDX) begin
            rd2_s = {DATA_WIDTH{1'b0}};
        end
`ifdef REG_WRITEBACK_BYPASS_EN
        else if (write_en_s && (RA2 == RdW)) begin
            rd2_s = result_s;
        end
`endif
        else begin
            rd2_s = regs_r[RA2];
        end
    end

    assign RD1     = rd1_s;
    assign RD2     = rd2_s;
    assign ResultW = result_s;
    assign a0      = regs_r[A0_IDX];
    assign WbCount = wb_count_r;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed testbench for reg_writeback: reset behaviour, memory lane
// extraction/extension, x0 handling, invalid codes, read-port visibility
// (bypass or not, matching the build macro) and counter wrap.
module tb_reg_writeback;

    logic        clk;
    logic        rst;
    logic [2:0]  RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [31:0] ImmExtW;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic [31:0] a0;
    logic [31:0] WbCount;

    int vectors;
    int miscompares;
    logic [31:0] exp_count;

    reg_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RdW        (RdW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .ImmExtW    (ImmExtW),
        .RA1        (RA1),
        .RA2        (RA2),
        .RD1        (RD1),
        .RD2        (RD2),
        .ResultW    (ResultW),
        .a0         (a0),
        .WbCount    (WbCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RA1 = 5'd5; RA2 = 5'd10;
        RegWriteW = 3'b000; ResultSrcW = 2'b00; ALUResultW = 32'h0000_A5A5;
        #1;
        vectors++;
        if (RD1 !== 32'h0) begin miscompares++; $display("FAIL reset_rd1 got %h want %h", RD1, 32'h0); end
        vectors++;
        if (WbCount !== 32'h0) begin miscompares++; $display("FAIL reset_count got %h want %h", WbCount, 32'h0); end
        vectors++;
        if (a0 !== 32'h0) begin miscompares++; $display("FAIL reset_a0 got %h want %h", a0, 32'h0); end
        vectors++;
        if (ResultW !== 32'h0000_A5A5) begin miscompares++; $display("FAIL result_nowrite got %h want %h", ResultW, 32'h0000_A5A5); end
    endtask

    task automatic test_reset_coincident();
        RegWriteW = 3'b001; ResultSrcW = 2'b00; RdW = 5'd5; ALUResultW = 32'h1111_1111;
        step();
        vectors++;
        if (RD1 !== 32'h0) begin miscompares++; $display("FAIL write_in_reset got %h want %h", RD1, 32'h0); end
        vectors++;
        if (WbCount !== 32'h0) begin miscompares++; $display("FAIL count_in_reset got %h want %h", WbCount, 32'h0); end
        rst = 1'b0;
        step();
        exp_count = 32'd1;
        vectors++;
        if (RD1 !== 32'h1111_1111) begin miscompares++; $display("FAIL first_write got %h want %h", RD1, 32'h1111_1111); end
        vectors++;
        if (WbCount !== exp_count) begin miscompares++; $display("FAIL first_count got %h want %h", WbCount, exp_count); end
    endtask

    task automatic test_midrun_reset();
        RegWriteW = 3'b001; ResultSrcW = 2'b00; RdW = 5'd5; ALUResultW = 32'h1234_5678; RA1 = 5'd5;
        step();
        RegWriteW = 3'b000;
        exp_count = exp_count + 32'd1;
        vectors++;
        if (RD1 !== 32'h1234_5678) begin miscompares++; $display("FAIL x5_write got %h want %h", RD1, 32'h1234_5678); end
        vectors++;
        if (WbCount !== exp_count) begin miscompares++; $display("FAIL x5_count got %h want %h", WbCount, exp_count); end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (RD1 !== 32'h0) begin miscompares++; $display("FAIL async_rst_rd1 got %h want %h", RD1, 32'h0); end
        vectors++;
        if (WbCount !== 32'h0) begin miscompares++; $display("FAIL async_rst_count got %h want %h", WbCount, 32'h0); end
        #1;
        rst = 1'b0;
        exp_count = 32'd0;
    endtask

    task automatic test_mem_extend();
        logic [2:0]  codes [6];
        logic [31:0] words [6];
        logic [31:0] addrs [6];
        logic [31:0] wants [6];
        codes[0] = 3'b010; words[0] = 32'h80FF_7F01; addrs[0] = 32'd1; wants[0] = 32'h0000_007F;
        codes[1] = 3'b010; words[1] = 32'h80FF_7F01; addrs[1] = 32'd3; wants[1] = 32'hFFFF_FF80;
        codes[2] = 3'b100; words[2] = 32'h80FF_7F01; addrs[2] = 32'd2; wants[2] = 32'h0000_00FF;
        codes[3] = 3'b011; words[3] = 32'h8001_ABCD; addrs[3] = 32'd2; wants[3] = 32'hFFFF_8001;
        codes[4] = 3'b101; words[4] = 32'h8001_ABCD; addrs[4] = 32'd0; wants[4] = 32'h0000_ABCD;
        codes[5] = 3'b011; words[5] = 32'h8001_ABCD; addrs[5] = 32'd3; wants[5] = 32'hFFFF_8001;
        ResultSrcW = 2'b01; RdW = 5'd3; RA2 = 5'd3;
        for (int i = 0; i < 6; i++) begin
            RegWriteW = codes[i]; ReadDataW = words[i]; ALUResultW = addrs[i];
            #1;
            vectors++;
            if (ResultW !== wants[i]) begin miscompares++; $display("FAIL ext_result[%0d] got %h want %h", i, ResultW, wants[i]); end
            step();
            exp_count = exp_count + 32'd1;
            vectors++;
            if (RD2 !== wants[i]) begin miscompares++; $display("FAIL ext_x3[%0d] got %h want %h", i, RD2, wants[i]); end
        end
        vectors++;
        if (WbCount !== exp_count) begin miscompares++; $display("FAIL ext_count got %h want %h", WbCount, exp_count); end
        RegWriteW = 3'b010; ResultSrcW = 2'b00; ALUResultW = 32'h80FF_7F01;
        #1;
        vectors++;
        if (ResultW !== 32'h80FF_7F01) begin miscompares++; $display("FAIL alu_full_width got %h want %h", ResultW, 32'h80FF_7F01); end
        RegWriteW = 3'b000;
    endtask

    task automatic test_x0_and_a0();
        RegWriteW = 3'b001; ResultSrcW = 2'b10; PCPlus4W = 32'h0000_0104; RdW = 5'd0; RA1 = 5'd0;
        step();
        vectors++;
        if (RD1 !== 32'h0) begin miscompares++; $display("FAIL x0_read got %h want %h", RD1, 32'h0); end
        vectors++;
        if (WbCount !== exp_count) begin miscompares++; $display("FAIL x0_count got %h want %h", WbCount, exp_count); end
        RdW = 5'd10;
        step();
        exp_count = exp_count + 32'd1;
        vectors++;
        if (a0 !== 32'h0000_0104) begin miscompares++; $display("FAIL a0_write got %h want %h", a0, 32'h0000_0104); end
        vectors++;
        if (WbCount !== exp_count) begin miscompares++; $display("FAIL a0_count got %h want %h", WbCount, exp_count); end
        RegWriteW = 3'b000;
    endtask

    task automatic test_invalid_code();
        logic [2:0] bad [2];
        bad[0] = 3'b110; bad[1] = 3'b111;
        ResultSrcW = 2'b00; ALUResultW = 32'hCAFE_BABE; RdW = 5'd10;
        for (int i = 0; i < 2; i++) begin
            RegWriteW = bad[i];
            #1;
            vectors++;
            if (ResultW !== 32'hCAFE_BABE) begin miscompares++; $display("FAIL invalid_result[%0d] got %h want %h", i, ResultW, 32'hCAFE_BABE); end
            step();
            vectors++;
            if (a0 !== 32'h0000_0104) begin miscompares++; $display("FAIL invalid_a0[%0d] got %h want %h", i, a0, 32'h0000_0104); end
            vectors++;
            if (WbCount !== exp_count) begin miscompares++; $display("FAIL invalid_count[%0d] got %h want %h", i, WbCount, exp_count); end
        end
        RegWriteW = 3'b000;
    endtask

    task automatic test_same_cycle_read();
        logic [31:0] early;
        RegWriteW = 3'b001; ResultSrcW = 2'b00; ALUResultW = 32'h0000_0777; RdW = 5'd7;
        step();
        exp_count = exp_count + 32'd1;
`ifdef REG_WRITEBACK_BYPASS_EN
        early = 32'hDEAD_0000;
`else
        early = 32'h0000_0777;
`endif
        ResultSrcW = 2'b11; ImmExtW = 32'hDEAD_0000; RA1 = 5'd7; RA2 = 5'd7;
        #1;
        vectors++;
        if (RD1 !== early) begin miscompares++; $display("FAIL same_cycle_rd1 got %h want %h", RD1, early); end
        vectors++;
        if (RD2 !== early) begin miscompares++; $display("FAIL same_cycle_rd2 got %h want %h", RD2, early); end
        step();
        exp_count = exp_count + 32'd1;
        RegWriteW = 3'b000;
        #1;
        vectors++;
        if (RD1 !== 32'hDEAD_0000) begin miscompares++; $display("FAIL next_cycle_rd1 got %h want %h", RD1, 32'hDEAD_0000); end
        vectors++;
        if (RD2 !== 32'hDEAD_0000) begin miscompares++; $display("FAIL next_cycle_rd2 got %h want %h", RD2, 32'hDEAD_0000); end
        vectors++;
        if (WbCount !== exp_count) begin miscompares++; $display("FAIL same_cycle_count got %h want %h", WbCount, exp_count); end
    endtask

    task automatic test_count_wrap();
        force dut.wb_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_r;
        RegWriteW = 3'b001; ResultSrcW = 2'b00; ALUResultW = 32'h0000_0001; RdW = 5'd1;
        step();
        vectors++;
        if (WbCount !== 32'h0) begin miscompares++; $display("FAIL count_wrap got %h want %h", WbCount, 32'h0); end
        RegWriteW = 3'b111;
        step();
        vectors++;
        if (WbCount !== 32'h0) begin miscompares++; $display("FAIL count_after_111 got %h want %h", WbCount, 32'h0); end
        RegWriteW = 3'b000;
    endtask

    initial begin
        vectors = 0; miscompares = 0; exp_count = 32'd0;
        rst = 1'b1;
        RegWriteW = 3'b000; ResultSrcW = 2'b00; RdW = 5'd0;
        ALUResultW = 32'h0; ReadDataW = 32'h0; PCPlus4W = 32'h0; ImmExtW = 32'h0;
        RA1 = 5'd0; RA2 = 5'd0;
        #12;
        test_reset();
        test_reset_coincident();
        test_midrun_reset();
        test_mem_extend();
        test_x0_and_a0();
        test_invalid_code();
        test_same_cycle_read();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register and datapath width.
REQ-002 Parameter ADDR_WIDTH, default 5: register index width, giving 2**ADDR_WIDTH architectural registers.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 RegWriteW  input  3  write/extension code from the MEM/WB pipeline register.
REQ-006 ResultSrcW  input  2  result source select from the MEM/WB pipeline register.
REQ-007 RdW  input  ADDR_WIDTH  destination register index.
REQ-008 ALUResultW, ReadDataW, PCPlus4W, ImmExtW  input  DATA_WIDTH each  candidate results; ReadDataW is the raw aligned memory word.
REQ-009 RA1, RA2  input  ADDR_WIDTH  read-port indices (decode stage).
REQ-010 RD1, RD2  output  DATA_WIDTH  read-port data.
REQ-011 ResultW  output  DATA_WIDTH  selected, extended writeback value (for forwarding).
REQ-012 a0  output  DATA_WIDTH  live contents of x10.
REQ-013 WbCount  output  32  count of committed register writes.

Function
REQ-014 RegWriteW codes: 000 no write; 001 word; 010 byte signed; 011 half signed; 100 byte unsigned; 101 half unsigned; 110/111 no write.
REQ-015 ResultSrcW: 00 ALUResultW; 01 extended memory data; 10 PCPlus4W; 11 ImmExtW.
REQ-016 Memory lane select: byte = ReadDataW bits [8*ALUResultW[1:0] +: 8]; half = ReadDataW bits [16*ALUResultW[1] +: 16]; ALUResultW[0] ignored for half.
REQ-017 Extension per REQ-014 applies only when ResultSrcW = 01; other sources pass full width for any write code 001-101.
REQ-018 ResultW is combinational; it is valid even when no write occurs.
REQ-019 Write commits on posedge clk when code is 001-101 and RdW != 0; single-cycle latency; writes to x0 discarded.
REQ-020 RD1/RD2 combinational; index 0 reads 0 always.
REQ-021 WbCount increments by 1 on each committed write (REQ-019 only); wraps 0xFFFFFFFF -> 0 silently.
REQ-022 Same register read on both ports and written same cycle: both ports behave identically per Configuration.
REQ-023 Invalid code 110/111 with any RdW: no write, no count, ResultW still driven.

Reset
REQ-024 rst high asserts immediately, independent of clk: all registers 0, WbCount 0, a0 0.
REQ-025 Write coincident with rst asserted is dropped; count not incremented.
REQ-026 First write accepted on first posedge after rst deasserts.

Configuration
REQ-027 Macro REG_WRITEBACK_BYPASS_EN.
REQ-028 Defined: if RA1 or RA2 equals a nonzero RdW with a committing write code, the port returns ResultW in the same cycle (write-then-read).
REQ-029 Undefined: ports return the stored value; new data visible the cycle after commit; pipeline relies on negedge-free hazard stall.

Verification
REQ-030 rst pulse mid-run after x5=0x12345678 -> RD1(RA1=5)=0, WbCount=0 immediately, without clock edge.
REQ-031 ReadDataW=0x80FF7F01, ALUResultW=1, code 010, src 01, RdW=3 -> x3=0x0000007F; ALUResultW=3 -> x3=0xFFFFFF80; code 100 ALUResultW=2 -> 0x000000FF.
REQ-032 ReadDataW=0x8001ABCD, ALUResultW=2, code 011 -> 0xFFFF8001; code 101 ALUResultW=0 -> 0x0000ABCD.
REQ-033 code 001, src 10, PCPlus4W=0x104, RdW=0 -> x0 reads 0, WbCount unchanged; RdW=10 -> a0=0x104, WbCount+1.
REQ-034 code 001, src 11, ImmExtW=0xDEAD0000, RdW=7, RA1=RA2=7 same cycle -> with macro RD1=RD2=0xDEAD0000 that cycle; without, old value then 0xDEAD0000 next cycle.
REQ-035 Preload WbCount to 0xFFFFFFFF via 2^32-1 commits (or forced) then one commit -> WbCount=0; code 111 -> no change.
